// File: rtl/reg_scoreboard.sv
// Per-register pending write-back counter. ID-stage freeze is decided from the counts
// rather than from a fixed pipeline window, so variable-latency stages are covered.
module reg_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int REG_W     = 4,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_wb_en,
  input  logic [REG_W-1:0]       issue_dest,
  input  logic                   flush,
  input  logic [REG_W-1:0]       src1,
  input  logic [REG_W-1:0]       src2,
  input  logic                   two_src,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_dest,
  output logic                   freeze,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [REG_W+CNT_W-1:0] inflight,
  output logic                   err
);

  localparam int DEPTH = 2**REG_W;
  localparam int INF_W = REG_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Storage spans the full index space; entries >= NUM_REGS never leave 0.
  logic [CNT_W-1:0]    cnt     [DEPTH];
  logic [CNT_W-1:0]    cnt_nxt [DEPTH];
  logic [DEPTH-1:0]    in_range;
  logic [NUM_REGS-1:0] busy_nxt;

  logic [CNT_W-1:0] cnt_src1, cnt_src2, cnt_dest, cnt_wb;
  logic byp1, byp2, haz1, haz2, sat;
  logic issue_try, acc, ret, err_set;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) in_range[i] = (i < NUM_REGS);
  end

  assign cnt_src1 = cnt[src1];
  assign cnt_src2 = cnt[src2];
  assign cnt_dest = cnt[issue_dest];
  assign cnt_wb   = cnt[wb_dest];

  // A same-cycle write-back of the last pending write releases the source.
  assign byp1 = (WB_BYPASS != 0) && wb_valid && (wb_dest == src1) && (cnt_src1 == CNT_ONE);
  assign byp2 = (WB_BYPASS != 0) && wb_valid && (wb_dest == src2) && (cnt_src2 == CNT_ONE);

  assign haz1   = (cnt_src1 != '0) && !byp1;
  assign haz2   = two_src && (cnt_src2 != '0) && !byp2;
  assign sat    = issue_wb_en && (cnt_dest == CNT_MAX);
  assign freeze = issue_valid && (haz1 || haz2 || sat);

  assign issue_try = issue_valid && issue_wb_en && !freeze && !flush;
  assign acc       = issue_try && in_range[issue_dest];
  assign ret       = wb_valid && (cnt_wb != '0);
  assign err_set   = (wb_valid && (cnt_wb == '0))
                   || (issue_try && !in_range[issue_dest])
                   || (acc && (cnt_dest == CNT_MAX));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (acc && (issue_dest == REG_W'(i)) && !(ret && (wb_dest == REG_W'(i))))
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      else if (ret && (wb_dest == REG_W'(i)) && !(acc && (issue_dest == REG_W'(i))))
        cnt_nxt[i] = cnt[i] - CNT_ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) busy_nxt[i] = (cnt_nxt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
      busy_mask <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= cnt_nxt[i];
      busy_mask <= busy_nxt;
      inflight  <= inflight + INF_W'(acc) - INF_W'(ret);
      err       <= err | err_set;
    end
  end

  // Saturation freezes the issue, so an accepted issue can never overflow a counter.
  assert property (@(posedge clk) disable iff (rst) !(acc && (cnt_dest == CNT_MAX)));

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks, per architectural register, how many issued instructions are still in flight with a pending write-back.
- Sits beside the ID stage of the ARM pipeline:
  - Instructions leaving ID register their destination here.
  - The WB stage retires it.
  - The ID-stage source query gets a freeze decision from the pending-write counts, not from a fixed EXE/MEM window.
- Covers variable-latency stages, e.g. multi-cycle memory, where the in-flight window is longer than EXE+MEM.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked.
- REG_W, 4, register index width; NUM_REGS <= 2**REG_W.
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2**CNT_W-1.
- WB_BYPASS, 1, when 1 a write-back in the current cycle releases a source whose count is exactly 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  instruction in ID is attempting to advance this cycle.
- issue_wb_en  input  1  that instruction writes a register.
- issue_dest  input  REG_W  its destination register.
- flush  input  1  ID instruction is squashed this cycle (taken branch); suppresses issue.
- src1  input  REG_W  first source of the ID instruction.
- src2  input  REG_W  second source of the ID instruction.
- two_src  input  1  src2 is a real operand.
- wb_valid  input  1  WB stage commits a register write this cycle.
- wb_dest  input  REG_W  register written by WB.
- freeze  output  1  ID must hold; combinational from registered counts and current inputs.
- busy_mask  output  NUM_REGS  bit r = 1 iff count[r] != 0; registered.
- inflight  output  REG_W+CNT_W  total pending writes across all registers; registered.
- err  output  1  sticky error flag; registered.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All counts, busy_mask, inflight and err go to 0, regardless of other inputs in that cycle.
  - With all counts 0, freeze evaluates to 0.
  - Reset mid-operation discards all pending state; later wb_valid for pre-reset instructions counts as underflow.
- Source hazard, per source s in {src1, src2 when two_src=1}:
  - hazard_s = count[s] != 0.
  - If WB_BYPASS=1, hazard_s is cleared when wb_valid=1, wb_dest==s and count[s]==1.
- Saturation hazard: sat = issue_wb_en && count[issue_dest] == max.
- freeze = issue_valid && (hazard_src1 || hazard_src2 || sat). freeze has no combinational dependency on flush.
- Issue acceptance: acc = issue_valid && issue_wb_en && !freeze && !flush.
- Write-back retirement: ret = wb_valid && count[wb_dest] != 0.
- Per-register counter update at the clock edge:
  - acc only on r: count[r] + 1.
  - ret only on r: count[r] - 1.
  - acc and ret on the same r: unchanged.
  - acc and ret on different registers: both apply.
- inflight updates by +acc - ret in the same cycle; it always equals the sum of all counts.
- Underflow: wb_valid with count[wb_dest]==0 leaves the count unchanged and sets err.
- err also sets if acc would ever exceed max. This is unreachable by construction and is an assertion target for verification.
- err clears only on rst.
- Latency:
  - Issue to busy_mask/freeze visibility: 1 cycle.
  - Write-back to release: 0 cycles with WB_BYPASS=1, 1 cycle otherwise.
- Indices >= NUM_REGS on any port are treated as count 0 / no-op. issue to such an index is not accepted and sets err.

Test Plan:
1. Reset, then issue_valid=1, issue_wb_en=1, issue_dest=3. Next cycle: busy_mask=0x0008, inflight=1. ID with src1=3 gives freeze=1. Then wb_valid=1, wb_dest=3 with WB_BYPASS=1: freeze=0 that same cycle, and busy_mask=0 next cycle.
2. two_src=0, src2=5, count[5]=1 -> freeze=0. Set two_src=1 -> freeze=1. src1=5 with count[5]=0 and two_src=0 -> freeze=0.
3. Issue to R7 three times (CNT_W=2), then a fourth issue to R7 with sources free -> freeze=1, count[7] stays 3. One wb to R7 -> count[7]=2. Fourth issue then accepted -> count[7]=3.
4. Same cycle: acc to R2 and wb to R2 with count[2]=1 -> count[2]=1, inflight unchanged. acc to R4 and wb to R9 -> inflight unchanged, busy bit 4 set, bit 9 cleared.
5. flush=1 with issue_valid=1, issue_dest=1 -> count[1] stays 0, freeze unaffected by flush. wb_valid to R6 with count[6]=0 -> err=1, counts unchanged; err stays 1 until rst.
6. Load 4 pending writes, assert rst for one cycle together with an issue and a wb -> all outputs 0 next cycle, freeze=0, err=0.
